// File: rtl/out_spike_packetizer.sv
// Output spike packetizer: captures per-neuron fire events per timestep and
// streams one {SRC_ID, neuron} packet per fired neuron to the router.
module out_spike_packetizer #(
  parameter int NUM_NEURONS          = 256,
  parameter int NEURON_CNT_BIT_WIDTH = 8,
  parameter int SRC_ID_WIDTH         = 8,
  parameter logic [SRC_ID_WIDTH-1:0] SRC_ID = '0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_n_i,
  input  logic                                         spikeWrEn_i,
  input  logic [NEURON_CNT_BIT_WIDTH-1:0]              spikeAddr_i,
  input  logic                                         spike_i,
  input  logic                                         flush_i,
  input  logic                                         pkt_ready_i,
  output logic                                         pkt_valid_o,
  output logic [SRC_ID_WIDTH+NEURON_CNT_BIT_WIDTH-1:0] pkt_data_o,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [NEURON_CNT_BIT_WIDTH:0]                spikeCnt_o,
  output logic                                         overrun_o
);

  localparam int AW = NEURON_CNT_BIT_WIDTH;
  localparam int DW = SRC_ID_WIDTH + AW;
  localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SEND,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [NUM_NEURONS-1:0] cap_q, cap_d;
  logic [NUM_NEURONS-1:0] tx_q, tx_d;
  logic [NUM_NEURONS-1:0] wr_vec;
  logic [AW-1:0]          idx_q, idx_d;
  logic [AW:0]            sent_q, sent_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   vld_q, vld_d;
  logic [DW-1:0]          data_q, data_d;
  logic                   ovr_q, ovr_d;
  logic                   idx_last;

  // Out-of-range addresses match no entry and are dropped.
  always_comb begin
    wr_vec = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      wr_vec[i] = spikeWrEn_i & spike_i &
                  (spikeAddr_i == AW'(i));
    end
  end

  assign idx_last = (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q | wr_vec;
    tx_d    = tx_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    data_d  = data_q;
    ovr_d   = ovr_q;

    if (flush_i && state_q != IDLE) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          tx_d    = cap_q | wr_vec;
          cap_d   = '0;
          idx_d   = '0;
          sent_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (tx_q[idx_q]) begin
          data_d  = {SRC_ID, idx_q};
          vld_d   = 1'b1;
          state_d = SEND;
        end else if (idx_last) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEND: begin
        if (vld_q && pkt_ready_i) begin
          vld_d  = 1'b0;
          sent_d = sent_q + 1'b1;
          if (idx_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        cnt_d   = sent_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cap_q   <= '0;
      tx_q    <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      tx_q    <= tx_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pkt_valid_o = vld_q;
  assign pkt_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign spikeCnt_o  = cnt_q;
  assign overrun_o   = ovr_q;

endmodule

// File: doc/out_spike_packetizer.md
Name: out_spike_packetizer

Overview:
Output-side counterpart of the crossbar input spike buffer. It collects per-neuron fire events during a timestep into a capture bitmap. On flush it snapshots the bitmap and scans it, emitting one packet per fired neuron to the NoC router over a valid/ready handshake. Double buffering lets the next timestep's spikes accumulate while the previous timestep is still being transmitted.

Parameters:
NUM_NEURONS, 256, number of neurons in the core; scan range is 0..NUM_NEURONS-1
NEURON_CNT_BIT_WIDTH, 8, width of the neuron address; NUM_NEURONS <= 2^NEURON_CNT_BIT_WIDTH
SRC_ID_WIDTH, 8, width of the core source ID field in the packet
SRC_ID, 0, this core's source ID, placed in the packet MSBs

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
spikeWrEn_i  in  1  neuron result write strobe
spikeAddr_i  in  NEURON_CNT_BIT_WIDTH  neuron index of the write
spike_i  in  1  1 = neuron fired
flush_i  in  1  end of timestep: snapshot the capture bitmap and start transmission
pkt_ready_i  in  1  router accepts the packet
pkt_valid_o  out  1  packet valid
pkt_data_o  out  SRC_ID_WIDTH+NEURON_CNT_BIT_WIDTH  packet {SRC_ID, neuron index}
busy_o  out  1  transmission in progress
done_o  out  1  one-cycle pulse when the scan completes
spikeCnt_o  out  NEURON_CNT_BIT_WIDTH+1  packets sent in the last completed timestep
overrun_o  out  1  sticky: flush_i arrived while busy

Behaviour:
- Reset (async): CapBuf=0, TxBuf=0, state=IDLE, idx=0.
- Reset output values: pkt_valid_o=0, pkt_data_o=0, busy_o=0, done_o=0, spikeCnt_o=0, overrun_o=0.
- Reset mid-transfer: pkt_valid_o drops immediately; the in-flight packet is lost.
- Capture:
  - At each edge with spikeWrEn_i=1 and spike_i=1, set CapBuf[spikeAddr_i]=1.
  - spike_i=0 has no effect; bits are never individually cleared.
  - Writes with spikeAddr_i >= NUM_NEURONS are ignored.
  - Writes are accepted in every state, including while busy.
- Flush (state IDLE, flush_i=1) at edge k:
  - TxBuf <= CapBuf | (this cycle's write bit, if any).
  - CapBuf <= 0. A write in the same cycle lands in TxBuf, not CapBuf.
  - idx <= 0, sent counter <= 0, state <= SCAN.
- flush_i while state != IDLE: ignored, no snapshot; overrun_o <= 1. overrun_o clears only on reset.
- FSM states: IDLE, SCAN, SEND, DONE.
  - IDLE -> SCAN on flush_i.
  - SCAN examines TxBuf[idx] each cycle.
    - Bit=1: register pkt_data_o={SRC_ID,idx}, pkt_valid_o<=1, go to SEND.
    - Bit=0 and idx=NUM_NEURONS-1: go to DONE.
    - Otherwise idx<=idx+1.
  - SEND holds pkt_valid_o and pkt_data_o stable until pkt_valid_o & pkt_ready_i at an edge. Then:
    - pkt_valid_o<=0, sent counter +1.
    - If idx=NUM_NEURONS-1 go to DONE, else idx<=idx+1 and go to SCAN.
  - DONE: done_o=1 for exactly this one cycle; spikeCnt_o <= sent counter; next state IDLE.
- Latency:
  - First packet: valid rises after edge k+1 if neuron 0 fired.
  - pkt_valid_o is low for at least one cycle between packets; peak rate is 1 packet per 2 cycles.
- With zero spikes: SCAN occupies edges k+1..k+NUM_NEURONS, and done_o is high in the cycle after edge k+NUM_NEURONS.
- busy_o = (state != IDLE).
- A flush is accepted again in the cycle after the DONE cycle (state IDLE).
- pkt_valid_o never deasserts without a handshake except on reset.
- Packets are emitted in ascending neuron index order.

Test Plan:
- Reset: assert rst_n_i=0 mid-run -> all outputs 0 immediately; after release, no pkt_valid_o without a flush.
- Write spikes at 3 and 200, flush, pkt_ready_i=1 -> exactly two packets {SRC_ID,3} then {SRC_ID,200}; done_o one pulse; spikeCnt_o=2; busy_o low after DONE.
- Flush with no spikes -> pkt_valid_o stays 0; done_o high in the cycle after edge flush+256; spikeCnt_o=0.
- Backpressure: spike at 5, pkt_ready_i=0 for 6 cycles then 1 -> pkt_data_o={SRC_ID,5} stable and valid held all 6 cycles; exactly one handshake.
- Overlap: spikes 1..4, flush; during transmission write spike 9 and pulse flush_i again -> second flush ignored, overrun_o=1; the next flush after done emits only {SRC_ID,9}.
- Same-cycle write+flush at addr 7 -> packet 7 sent in the current timestep; the next flush with no writes emits nothing. Addr 255 fired -> last packet; done follows its handshake.
